// File: rtl/parking_lot_manager.sv
// parking_lot_manager: debounced slot occupancy counts plus gate FSM.
// Ports: clk, reset (sync, active-high); slot_sensor[SLOTS] raw occupancy;
//   entry_req/exit_req levels in; entry_grant/entry_denied/exit_grant
//   one-cycle pulses; gate_open actuator; parked/empty/pending counts;
//   full when no space remains for another admitted car.
module parking_lot_manager #(
    parameter int SLOTS       = 8,
    parameter int CNT_W       = 4,
    parameter int DEBOUNCE    = 3,
    parameter int GATE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SLOTS-1:0] slot_sensor,
    input  logic             entry_req,
    input  logic             exit_req,
    output logic             entry_grant,
    output logic             entry_denied,
    output logic             exit_grant,
    output logic             gate_open,
    output logic [CNT_W-1:0] parked,
    output logic [CNT_W-1:0] empty,
    output logic [CNT_W-1:0] pending,
    output logic             full
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int TM_W = $clog2(GATE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(SLOTS);
    localparam logic [CNT_W:0]   SLOTS_W = (CNT_W+1)'(SLOTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        EXIT  = 2'd2
    } state_t;

    state_t            state;
    logic [TM_W-1:0]   timer;
    logic [SLOTS-1:0]  stable_q;
    logic [DB_W-1:0]   db_cnt [SLOTS];
    logic [CNT_W-1:0]  parked_next;
    logic [CNT_W-1:0]  inc;
    logic [CNT_W:0]    used;
    logic [CNT_W-1:0]  avail;
    logic [CNT_W:0]    pend_sum;
    logic [CNT_W:0]    pend_dec;
    logic [CNT_W:0]    pend_new;
    logic              grant_now;

    // Per-bit debounce: a bit is accepted only after DEBOUNCE
    // consecutive samples disagreeing with the accepted value.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= '0;
            for (int i = 0; i < SLOTS; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (slot_sensor[i] == stable_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
                    stable_q[i] <= slot_sensor[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        parked_next = '0;
        for (int i = 0; i < SLOTS; i++)
            parked_next = parked_next + CNT_W'(stable_q[i]);
    end

    // Space already promised to admitted cars counts as taken.
    always_comb begin
        used  = {1'b0, parked} + {1'b0, pending};
        avail = (used >= SLOTS_W) ? '0 : CNT_W'(SLOTS_W - used);
    end

    assign full = (avail == '0);

    assign grant_now = (state == IDLE) && !exit_req &&
                       entry_req && !full;

    // Newly parked cars retire pending admissions; departures do not.
    always_comb begin
        inc      = (parked_next > parked) ? parked_next - parked : '0;
        pend_sum = {1'b0, pending} + (CNT_W+1)'(grant_now);
        pend_dec = (pend_sum < {1'b0, inc}) ? pend_sum : {1'b0, inc};
        pend_new = pend_sum - pend_dec;
        if (pend_new > SLOTS_W) pend_new = SLOTS_W;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            parked  <= '0;
            empty   <= SLOTS_C;
            pending <= '0;
        end else begin
            parked  <= parked_next;
            empty   <= SLOTS_C - parked_next;
            pending <= pend_new[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            gate_open    <= 1'b0;
            entry_grant  <= 1'b0;
            entry_denied <= 1'b0;
            exit_grant   <= 1'b0;
        end else begin
            entry_grant  <= 1'b0;
            entry_denied <= 1'b0;
            exit_grant   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (exit_req) begin
                        exit_grant <= 1'b1;
                        gate_open  <= 1'b1;
                        timer      <= TM_W'(GATE_CYCLES);
                        state      <= EXIT;
                    end else if (entry_req) begin
                        if (!full) begin
                            entry_grant <= 1'b1;
                            gate_open   <= 1'b1;
                            timer       <= TM_W'(GATE_CYCLES);
                            state       <= ENTRY;
                        end else begin
                            entry_denied <= 1'b1;
                        end
                    end
                end
                ENTRY, EXIT: begin
                    timer <= timer - 1'b1;
                    if (timer == TM_W'(1)) begin
                        gate_open <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gate_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/parking_lot_manager.md
Name: parking_lot_manager

Overview:
- Parametrised, clocked successor to the combinational parking occupancy counter.
- Debounces a vector of per-slot occupancy sensors and keeps registered parked/empty counts.
- Tracks cars admitted but not yet parked.
- Runs a gate FSM that grants or denies entry and exit requests. Sits between slot sensors and the gate/display logic of the parking controller.

Parameters:
- SLOTS, 8, number of parking slots (sensor bits); 1..15.
- CNT_W, 4, width of all count outputs; 2^CNT_W must exceed SLOTS.
- DEBOUNCE, 3, consecutive disagreeing samples before a sensor bit is accepted; >=1.
- GATE_CYCLES, 4, cycles the gate stays open per grant; >=1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- slot_sensor  in  SLOTS  raw occupancy, bit i = 1 means a car is in slot i.
- entry_req  in  1  level; held by the requester until entry_grant or entry_denied.
- exit_req  in  1  level; held until exit_grant.
- entry_grant  out  1  one-cycle pulse: entry accepted.
- entry_denied  out  1  one-cycle pulse: lot full.
- exit_grant  out  1  one-cycle pulse: exit accepted.
- gate_open  out  1  gate actuator.
- parked  out  CNT_W  debounced occupied-slot count.
- empty  out  CNT_W  SLOTS - parked.
- pending  out  CNT_W  cars admitted, not yet seen parked.
- full  out  1  available space == 0.

Behaviour:
- One clock domain; reset is synchronous and active-high, sampled on rising clk.
- Reset values:
  - stable sensor vector = 0; debounce counters = 0.
  - parked = 0, empty = SLOTS, pending = 0, full = 0.
  - All pulses = 0, gate_open = 0, FSM = IDLE, timer = 0.
  - Reset mid-gate closes the gate at that same edge.
- Debounce, per bit i:
  - If raw[i] == stable[i], cnt_i <= 0.
  - Otherwise cnt_i increments. On the DEBOUNCE-th consecutive disagreeing edge, stable[i] <= raw[i] and cnt_i <= 0.
  - A single agreeing sample restarts the count.
  - With DEBOUNCE=1, stable follows raw with one edge of delay.
- Counts:
  - parked <= popcount(stable) and empty <= SLOTS - parked, both registered.
  - Latency from the first changed raw sample to the parked update is DEBOUNCE+1 edges.
  - All arithmetic is CNT_W wide, unsigned, with no wrap: parked <= SLOTS by construction.
- Space and full:
  - avail = SLOTS - parked - pending, saturated at 0 (internal, combinational).
  - full = (avail == 0), combinational from registers.
- pending:
  - Next value = pending + entry_grant - min(pending_plus_grant, inc), where inc = max(0, parked_next - parked).
  - Floor at 0; never exceeds SLOTS.
  - Decreases of parked do not affect pending.
- FSM states: IDLE, ENTRY, EXIT.
  - IDLE, exit_req=1: exit_grant pulse, gate_open <= 1, timer <= GATE_CYCLES, go to EXIT.
    - Exit has priority over a simultaneous entry_req.
    - Exit is granted regardless of counts.
  - IDLE, entry_req=1 (and exit_req=0) with full=0: entry_grant pulse, pending increments, gate_open <= 1, timer <= GATE_CYCLES, go to ENTRY.
  - IDLE, entry_req=1 (and exit_req=0) with full=1: entry_denied pulse. Stay IDLE; the denial repeats each cycle the request is held.
  - ENTRY/EXIT: the timer decrements each edge. At timer == 1, return to IDLE with gate_open <= 0.
    - gate_open is high exactly GATE_CYCLES cycles.
    - Requests are ignored (not queued) while not IDLE.
  - A held request is re-evaluated on the first IDLE cycle.
- Grant/denied outputs are registered: they rise on the edge after the request is sampled in IDLE.
- Sensor changes during a gate cycle are processed normally; the counts never stall.

Test Plan:
1. Reset, then slot_sensor=8'h00 -> parked=0, empty=8, full=0, gate_open=0, pending=0.
2. Set slot_sensor=8'h0F in one cycle -> parked=4, empty=4 exactly 4 edges later (DEBOUNCE=3). A 2-cycle glitch to 8'h1F -> no count change.
3. slot_sensor=8'h7F stable, entry_req held -> entry_grant 1 cycle, pending=1, full=1, gate_open high 4 cycles. A second entry_req -> entry_denied pulse, no gate. Raise bit 7 -> after 4 edges parked=8, pending=0, empty=0, full=1.
4. entry_req and exit_req asserted together in IDLE with parked=3 -> exit_grant only. After the gate closes, entry_grant follows.
5. Assert reset on the 2nd gate_open cycle -> gate_open=0, FSM IDLE, pending=0, parked=0 next cycle.
6. SLOTS=12, CNT_W=4, all sensors set -> parked=12, empty=0. Clear 5 bits -> parked=7, empty=5.
